// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared types and helpers for the radix-2 butterfly engine.
//   - bfly_state_t : butterfly controller states
//   - sat_t / sat  : generic signed saturation to a run-time width, returning
//                    the clipped value together with a clip flag
// -----------------------------------------------------------------------------
package fft_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        SUM  = 3'd2,
        BFLY = 3'd3,
        DONE = 3'd4
    } bfly_state_t;

    // Wide enough to hold every intermediate of the butterfly before clipping.
    localparam int SAT_XW = 64;

    localparam logic signed [SAT_XW-1:0] SAT_ONE = {{(SAT_XW-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic signed [SAT_XW-1:0] val;
        logic                     clip;
    } sat_t;

    // Clamp x to the signed range of 'width' bits.
    function automatic sat_t sat(input logic signed [SAT_XW-1:0] x, input int width);
        logic signed [SAT_XW-1:0] hi;
        logic signed [SAT_XW-1:0] lo;
        sat_t r;
        hi = (SAT_ONE <<< (width - 1)) - SAT_ONE;
        lo = ~hi;
        if (x > hi) begin
            r.val  = hi;
            r.clip = 1'b1;
        end else if (x < lo) begin
            r.val  = lo;
            r.clip = 1'b1;
        end else begin
            r.val  = x;
            r.clip = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_mul_round.sv
// -----------------------------------------------------------------------------
// fft_mul_round
//   Single signed W x W real multiplier followed by optional round-half-up,
//   arithmetic shift right by FRAC and saturation to W+1 bits. Purely
//   combinational; the butterfly controller time-shares one instance.
// Ports
//   x, y  in   W    signed operands (y is the Q1.FRAC twiddle component)
//   p     out  W+1  rounded, shifted, saturated product
//   clip  out  1    product hit the W+1-bit limit
// -----------------------------------------------------------------------------
module fft_mul_round
    import fft_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = W - 1,
    parameter int ROUND = 1
) (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    output logic signed [W:0]   p,
    output logic                clip
);

    localparam logic signed [2*W:0] RND =
        (ROUND != 0) ? ((2*W+1)'(1) <<< (FRAC - 1)) : '0;

    logic signed [2*W-1:0] prod;
    logic signed [2*W:0]   prod_rnd;
    logic signed [2*W:0]   prod_sh;
    sat_t                  prod_sat;
    logic                  unused_prod_hi;

    always_comb begin
        prod     = (2*W)'(x) * (2*W)'(y);
        // One guard bit so the rounding constant cannot wrap the product.
        prod_rnd = (2*W+1)'(prod) + RND;
        prod_sh  = prod_rnd >>> FRAC;
        prod_sat = sat(SAT_XW'(prod_sh), W + 1);
    end

    assign p    = prod_sat.val[W:0];
    assign clip = prod_sat.clip;

    assign unused_prod_hi = ^prod_sat.val[SAT_XW-1:W+1];

endmodule

// File: rtl/fft_bfly_cplx.sv
// -----------------------------------------------------------------------------
// fft_bfly_cplx
//   Radix-2 DIT complex butterfly: y = a + w*b, z = a - w*b.
//   One shared real multiplier produces the four partial products over four
//   cycles; then the twiddled term t is formed, then the add/sub stage with
//   optional scale-by-1/2. Every saturation sets a sticky overflow flag.
//   Latency accept -> out_valid is 6 edges; back-to-back rate is one per 7.
// Ports
//   clk, rst                 clock (rising), asynchronous active-low reset
//   in_valid / in_ready      operand handshake (a, b, w, inv, scale)
//   a_re,a_im,b_re,b_im      operands, W-bit signed
//   w_re,w_im                twiddle, Q1.FRAC
//   inv                      1: use conj(w)
//   scale                    1: halve y and z
//   out_valid / out_ready    result handshake; y/z held while out_ready=0
//   y_re,y_im,z_re,z_im      results, saturated to W bits
//   ovf, clr_ovf             sticky overflow flag and its synchronous clear
// -----------------------------------------------------------------------------
module fft_bfly_cplx
    import fft_pkg::*;
#(
    parameter int W     = 16,
    parameter int FRAC  = W - 1,
    parameter int ROUND = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a_re,
    input  logic signed [W-1:0] a_im,
    input  logic signed [W-1:0] b_re,
    input  logic signed [W-1:0] b_im,
    input  logic signed [W-1:0] w_re,
    input  logic signed [W-1:0] w_im,
    input  logic                inv,
    input  logic                scale,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] y_re,
    output logic signed [W-1:0] y_im,
    output logic signed [W-1:0] z_re,
    output logic signed [W-1:0] z_im,
    output logic                ovf,
    input  logic                clr_ovf
);

    bfly_state_t         state_q;
    bfly_state_t         state_d;
    logic [1:0]          cnt_q;
    logic                accept;

    logic signed [W-1:0] a_re_p0, a_im_p0, b_re_p0, b_im_p0, w_re_p0, w_im_p0;
    logic                inv_p0, scale_p0;

    logic signed [W-1:0] mul_x, mul_y;
    logic signed [W:0]   mul_p;
    logic                mul_clip;
    logic signed [W:0]   prod_p1 [4];

    logic signed [W+1:0] sum_re, sum_im;
    sat_t                sat_tre, sat_tim;
    logic signed [W-1:0] t_re_p2, t_im_p2;

    sat_t                sat_yre, sat_yim, sat_zre, sat_zim;
    logic                ovf_set;
    logic                unused_sat_hi;

    // Halve a butterfly sum when scaling is selected (arithmetic, truncating).
    function automatic logic signed [W:0] half_if(input logic signed [W:0] v, input logic s);
        return s ? (v >>> 1) : v;
    endfunction

    // Full-precision add/sub of a and t, optional halving, then clip to W.
    function automatic sat_t bfly_leg(input logic signed [W-1:0] a, input logic signed [W-1:0] t,
                                      input logic sub, input logic s);
        logic signed [W:0] v;
        v = sub ? ((W+1)'(a) - (W+1)'(t)) : ((W+1)'(a) + (W+1)'(t));
        return sat(SAT_XW'(half_if(v, s)), W);
    endfunction

    // ---------------- controller ----------------
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = MUL;
            end
            MUL:  if (cnt_q == 2'd3) state_d = SUM;
            SUM:  state_d = BFLY;
            BFLY: state_d = DONE;
            DONE: begin
                // Handover: releasing the result and accepting the next set
                // happen on the same edge.
                in_ready = out_ready;
                if (out_ready) state_d = in_valid ? MUL : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            if (accept)              cnt_q <= 2'd0;
            else if (state_q == MUL) cnt_q <= cnt_q + 2'd1;
        end
    end

    // ---------------- stage 0: operand capture at accept ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_re_p0  <= '0;
            a_im_p0  <= '0;
            b_re_p0  <= '0;
            b_im_p0  <= '0;
            w_re_p0  <= '0;
            w_im_p0  <= '0;
            inv_p0   <= 1'b0;
            scale_p0 <= 1'b0;
        end else if (accept) begin
            a_re_p0  <= a_re;
            a_im_p0  <= a_im;
            b_re_p0  <= b_re;
            b_im_p0  <= b_im;
            w_re_p0  <= w_re;
            w_im_p0  <= w_im;
            inv_p0   <= inv;
            scale_p0 <= scale;
        end
    end

    // ---------------- stage 1: shared multiplier, products 0..3 ----------------
    // cnt 0: br*wr, 1: bi*wi, 2: br*wi, 3: bi*wr
    assign mul_x = cnt_q[0] ? b_im_p0 : b_re_p0;
    assign mul_y = (cnt_q == 2'd0 || cnt_q == 2'd3) ? w_re_p0 : w_im_p0;

    fft_mul_round #(
        .W     (W),
        .FRAC  (FRAC),
        .ROUND (ROUND)
    ) u_mul (
        .x    (mul_x),
        .y    (mul_y),
        .p    (mul_p),
        .clip (mul_clip)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) prod_p1[i] <= '0;
        end else if (state_q == MUL) begin
            prod_p1[cnt_q] <= mul_p;
        end
    end

    // ---------------- stage 2: twiddled term t = w*b (or conj(w)*b) ----------------
    always_comb begin
        if (inv_p0) begin
            sum_re = (W+2)'(prod_p1[0]) + (W+2)'(prod_p1[1]);
            sum_im = (W+2)'(prod_p1[3]) - (W+2)'(prod_p1[2]);
        end else begin
            sum_re = (W+2)'(prod_p1[0]) - (W+2)'(prod_p1[1]);
            sum_im = (W+2)'(prod_p1[2]) + (W+2)'(prod_p1[3]);
        end
        sat_tre = sat(SAT_XW'(sum_re), W);
        sat_tim = sat(SAT_XW'(sum_im), W);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_re_p2 <= '0;
            t_im_p2 <= '0;
        end else if (state_q == SUM) begin
            t_re_p2 <= sat_tre.val[W-1:0];
            t_im_p2 <= sat_tim.val[W-1:0];
        end
    end

    // ---------------- stage 3: butterfly add/sub, scale, result registers ----------------
    always_comb begin
        sat_yre = bfly_leg(a_re_p0, t_re_p2, 1'b0, scale_p0);
        sat_yim = bfly_leg(a_im_p0, t_im_p2, 1'b0, scale_p0);
        sat_zre = bfly_leg(a_re_p0, t_re_p2, 1'b1, scale_p0);
        sat_zim = bfly_leg(a_im_p0, t_im_p2, 1'b1, scale_p0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_re <= '0;
            y_im <= '0;
            z_re <= '0;
            z_im <= '0;
        end else if (state_q == BFLY) begin
            y_re <= sat_yre.val[W-1:0];
            y_im <= sat_yim.val[W-1:0];
            z_re <= sat_zre.val[W-1:0];
            z_im <= sat_zim.val[W-1:0];
        end
    end

    // ---------------- sticky overflow; a new clip beats a clear ----------------
    always_comb begin
        ovf_set = 1'b0;
        case (state_q)
            MUL:     ovf_set = mul_clip;
            SUM:     ovf_set = sat_tre.clip | sat_tim.clip;
            BFLY:    ovf_set = sat_yre.clip | sat_yim.clip | sat_zre.clip | sat_zim.clip;
            default: ovf_set = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         ovf <= 1'b0;
        else if (ovf_set) ovf <= 1'b1;
        else if (clr_ovf) ovf <= 1'b0;
    end

    assign unused_sat_hi = ^{sat_tre.val[SAT_XW-1:W], sat_tim.val[SAT_XW-1:W],
                             sat_yre.val[SAT_XW-1:W], sat_yim.val[SAT_XW-1:W],
                             sat_zre.val[SAT_XW-1:W], sat_zim.val[SAT_XW-1:W]};

endmodule

// File: tb/tb_fft_bfly_cplx.sv
module tb_fft_bfly_cplx;

    localparam int W = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0, w_re = '0, w_im = '0;
    logic                inv = 1'b0, scale = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] y_re, y_im, z_re, z_im;
    logic                ovf;
    logic                clr_ovf = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_bfly_cplx #(.W(W), .FRAC(W-1), .ROUND(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_re      (a_re),
        .a_im      (a_im),
        .b_re      (b_re),
        .b_im      (b_im),
        .w_re      (w_re),
        .w_im      (w_im),
        .inv       (inv),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y_re      (y_re),
        .y_im      (y_im),
        .z_re      (z_re),
        .z_im      (z_im),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    // ---------------- reference model (for the random stream) ----------------
    function automatic longint clampv(input longint v, input int bits);
        longint lim;
        lim = 64'sd1 <<< (bits - 1);
        if (v > lim - 1) return lim - 1;
        if (v < -lim)    return -lim;
        return v;
    endfunction

    function automatic longint rmul(input longint x, input longint y);
        return clampv((x * y + 64'sd16384) >>> 15, 17);
    endfunction

    function automatic logic [63:0] ref_bfly(input int ar, ai, br, bi, wr, wi, input bit iv, sc);
        longint p0, p1, p2, p3, tr, ti, yr, yi, zr, zi;
        logic [15:0] r0, r1, r2, r3;
        p0 = rmul(br, wr);
        p1 = rmul(bi, wi);
        p2 = rmul(br, wi);
        p3 = rmul(bi, wr);
        if (iv) begin tr = p0 + p1; ti = p3 - p2; end
        else    begin tr = p0 - p1; ti = p2 + p3; end
        tr = clampv(tr, 16);
        ti = clampv(ti, 16);
        yr = ar + tr; yi = ai + ti; zr = ar - tr; zi = ai - ti;
        if (sc) begin yr = yr >>> 1; yi = yi >>> 1; zr = zr >>> 1; zi = zi >>> 1; end
        r0 = 16'(clampv(yr, 16));
        r1 = 16'(clampv(yi, 16));
        r2 = 16'(clampv(zr, 16));
        r3 = 16'(clampv(zi, 16));
        return {r0, r1, r2, r3};
    endfunction

    // ---------------- stimulus helpers ----------------
    // Presents one operand set, waits for the accept edge, then scrambles the
    // inputs so only registered values can produce the result. lat = edges
    // from accept until out_valid (20 means it never came).
    task automatic run_one(input logic [15:0] ar, ai, br, bi, wr, wi,
                           input logic iv, sc, output int lat);
        int guard;
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        inv = iv; scale = sc; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin @(posedge clk); #1; guard++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        inv = ~iv; scale = ~sc;
        a_re = 16'h5A5A; a_im = 16'hA5A5; b_re = 16'h1234; b_im = 16'h4321;
        w_re = 16'h2222; w_im = 16'hDDDD;
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h0) begin
            errors++; $display("FAIL reset_yz: got %h want 0", {y_re, y_im, z_re, z_im}); end
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        run_one(16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", lat); end
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h1800_0000_0800_0000) begin
            errors++; $display("FAIL basic_yz: got %h want 1800000008000000", {y_re, y_im, z_re, z_im}); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_done: got %b want 0", in_ready); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", ovf); end
        retire();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_release: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    endtask

    task automatic test_inverse();
        int lat;
        run_one(16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b0, lat);
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h0000_FC00_0000_0400) begin
            errors++; $display("FAIL fwd_yz: got %h want 0000fc0000000400", {y_re, y_im, z_re, z_im}); end
        retire();
        run_one(16'h0000, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 16'h8000, 1'b1, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL inv_latency: got %0d want 6", lat); end
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h0000_0400_0000_FC00) begin
            errors++; $display("FAIL inv_yz: got %h want 000004000000fc00", {y_re, y_im, z_re, z_im}); end
        retire();
    endtask

    task automatic test_saturation();
        int lat;
        // 0x7FFF*0x7FFF rounds to 0x7FFE; a + t = 0xFFFD clips high.
        run_one(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, lat);
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h7FFF_0000_0001_0000) begin
            errors++; $display("FAIL sat_yz: got %h want 7fff000000010000", {y_re, y_im, z_re, z_im}); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf_set: got %b want 1", ovf); end
        retire();
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sat_ovf_clear: got %b want 0", ovf); end
        // Scaled: 0xFFFD >>> 1 = 0x7FFE, 1 >>> 1 = 0, no clip.
        run_one(16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b1, lat);
        checks++; if ({y_re, z_re} !== 32'h7FFE_0000) begin
            errors++; $display("FAIL scale_yz: got %h want 7ffe0000", {y_re, z_re}); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL scale_ovf: got %b want 0", ovf); end
        retire();
        // w = -1, b = -1: t_re = +1 clips to 0x7FFF; a + t clips again. clr_ovf held
        // over every edge, so the final clip must still win.
        clr_ovf = 1'b1;
        run_one(16'h4000, 16'h0000, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0, lat);
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h7FFF_0000_C001_0000) begin
            errors++; $display("FAIL neg1_yz: got %h want 7fff0000c0010000", {y_re, y_im, z_re, z_im}); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", ovf); end
        clr_ovf = 1'b0;
        retire();
    endtask

    task automatic test_back_to_back();
        int lat;
        int stable_bad;
        run_one(16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, lat);
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {y_re, y_im, z_re, z_im} !== 64'h1800_0000_0800_0000) begin
                errors++; stable_bad++;
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b yz=%h want ov=1 ir=0 yz=1800000008000000",
                         i, out_valid, in_ready, {y_re, y_im, z_re, z_im});
            end
        end
        out_ready = 1'b1; in_valid = 1'b1;
        a_re = 16'h0000; a_im = 16'h0000; b_re = 16'h0400; b_im = 16'h0000;
        w_re = 16'h0000; w_im = 16'h8000; inv = 1'b0; scale = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL handover_in_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0; inv = 1'b1; b_re = 16'h7777;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL handover_release: got %b want 0", out_valid); end
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 6) begin errors++; $display("FAIL handover_latency: got %0d want 6", lat); end
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h0000_FC00_0000_0400) begin
            errors++; $display("FAIL handover_yz: got %h want 0000fc0000000400", {y_re, y_im, z_re, z_im}); end
        retire();
    endtask

    task automatic test_reset_mid();
        int lat;
        a_re = 16'h7FFF; a_im = 16'h0000; b_re = 16'h7FFF; b_im = 16'h0000;
        w_re = 16'h7FFF; w_im = 16'h0000; inv = 1'b0; scale = 1'b0; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_pre_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h0 || out_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++; $display("FAIL mid_reset_outputs: got yz=%h ov=%b ovf=%b want 0", {y_re, y_im, z_re, z_im}, out_valid, ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b want 1", in_ready); end
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale: got %b want 0", out_valid); end
        run_one(16'h1000, 16'h0000, 16'h0800, 16'h0000, 16'h7FFF, 16'h0000, 1'b0, 1'b0, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL mid_after_latency: got %0d want 6", lat); end
        checks++; if ({y_re, y_im, z_re, z_im} !== 64'h1800_0000_0800_0000 || ovf !== 1'b0) begin
            errors++; $display("FAIL mid_after_yz: got %h ovf=%b want 1800000008000000 ovf=0", {y_re, y_im, z_re, z_im}, ovf); end
        retire();
    endtask

    task automatic test_stream();
        logic [15:0] sv [8][6];
        bit          siv [8];
        bit          ssc [8];
        logic [63:0] exp_r [8];
        int          idx_in, idx_out, last, cyc;
        bit          acc;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 6; j++) sv[k][j] = 16'($urandom);
            siv[k] = 1'($urandom);
            ssc[k] = 1'($urandom);
            exp_r[k] = ref_bfly($signed(sv[k][0]), $signed(sv[k][1]), $signed(sv[k][2]),
                                $signed(sv[k][3]), $signed(sv[k][4]), $signed(sv[k][5]),
                                siv[k], ssc[k]);
        end
        idx_in = 0; idx_out = 0; last = -1;
        out_ready = 1'b1; in_valid = 1'b1;
        {a_re, a_im, b_re, b_im, w_re, w_im} = {sv[0][0], sv[0][1], sv[0][2], sv[0][3], sv[0][4], sv[0][5]};
        inv = siv[0]; scale = ssc[0];
        for (cyc = 0; cyc < 150 && idx_out < 8; cyc++) begin
            if (out_valid) begin
                checks++;
                if ({y_re, y_im, z_re, z_im} !== exp_r[idx_out]) begin
                    errors++; $display("FAIL stream_yz%0d: got %h want %h", idx_out, {y_re, y_im, z_re, z_im}, exp_r[idx_out]);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last !== 7) begin
                        errors++; $display("FAIL stream_rate%0d: got %0d cycles want 7", idx_out, cyc - last);
                    end
                end
                last = cyc;
                idx_out++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                idx_in++;
                if (idx_in < 8) begin
                    {a_re, a_im, b_re, b_im, w_re, w_im} =
                        {sv[idx_in][0], sv[idx_in][1], sv[idx_in][2], sv[idx_in][3], sv[idx_in][4], sv[idx_in][5]};
                    inv = siv[idx_in]; scale = ssc[idx_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        checks++;
        if (idx_out !== 8) begin errors++; $display("FAIL stream_count: got %0d results want 8", idx_out); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverse();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
